retire_unit: RTL and testbench
==============================

# retire_unit

In-order commit stage directly downstream of the reorder buffer. Each cycle it examines the ROB head on the retire bus. When the head is complete it commits the head:
- writes the architectural register file;
- releases the register-status tag;
- runs a blocking store handshake to data memory;
- on a taken branch, raises a pipeline flush and PC redirect.

It produces the retire-enable that pops the ROB head, which makes it the sole consumer of ROB output.

## Interface
Parameters:
- XLEN, 32, data/address width
- TAG_W, 6, ROB tag width (64 entries)
- REG_W, 5, architectural register index width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- rb_valid  in  1  ROB head entry allocated
- rb_spec_valid  in  1  ROB head result written back
- rb_rd_tag  in  TAG_W  head tag
- rb_rd_reg  in  REG_W  destination register
- rb_data  in  XLEN  result; effective address for STORE; target PC for BRANCH
- rb_pc  in  XLEN  instruction PC
- rb_instr_type  in  dispatch_type  instruction class (INT, MULT, DIV, LOAD, STORE, BRANCH)
- rb_branch_taken  in  1  resolved branch outcome
- rb_store_data  in  XLEN  store payload
- retire_en  out  1  pop ROB head this cycle
- arf_wen  out  1  architectural register write
- arf_waddr  out  REG_W  write index
- arf_wdata  out  XLEN  write data
- rst_clr_en  out  1  clear register-status entry
- rst_clr_reg  out  REG_W  register whose tag is released
- rst_clr_tag  out  TAG_W  tag released; RST clears only on tag match
- mem_req  out  1  store request, held until acked
- mem_addr  out  XLEN  store address
- mem_wdata  out  XLEN  store data
- mem_ack  in  1  memory accepted store
- flush  out  1  squash all speculative state
- redirect_pc  out  XLEN  fetch restart address, valid with flush

## Operation
- The head is ready when `rb_valid & rb_spec_valid`.
- FSM states: RUN, ST_WAIT, FLUSH.
- RUN, head ready, type INT/MULT/DIV/LOAD:
  - `retire_en=1`.
  - `arf_wen=1` unless rd_reg==0.
  - `rst_clr_en=1` with rd_reg and rd_tag.
  - Stay in RUN.
- RUN, head ready, STORE:
  - Latch address and data, assert `mem_req`, go to ST_WAIT.
  - No retire_en yet.
- ST_WAIT:
  - Hold `mem_req`, mem_addr and mem_wdata stable.
  - On `mem_ack`: `retire_en=1`, deassert mem_req the next cycle, return to RUN.
- RUN, head ready, BRANCH:
  - `retire_en=1`.
  - No ARF write and no RST clear.
  - If `rb_branch_taken`: `flush=1` and `redirect_pc=rb_data` in the same cycle, go to FLUSH. Static not-taken prediction makes any taken branch a mispredict.
- FLUSH:
  - One drain cycle, all outputs low, ignore the retire bus.
  - Then RUN.
- At most one retirement per cycle.
- Head not ready: all strobes low.
- x0 is never written; a RST clear is still issued for x0.
- All retire outputs are combinational from the registered state and the retire bus. `mem_req`, `mem_addr` and `mem_wdata` are registered.

## Timing
- Reset, asynchronous: state=RUN, and mem_req, mem_addr, mem_wdata, flush, the perf counter and all strobes are 0.
- Non-store retire: 0 cycles from the head becoming ready. retire_en is in the same cycle; the ROB pops on the next edge.
- Store: mem_req rises 1 cycle after the head is ready. retire_en goes high in the cycle mem_ack is seen. Minimum 2 cycles per store.
- mem_ack outside ST_WAIT is ignored.
- Taken branch: flush is a single-cycle pulse, followed by one FLUSH cycle. The earliest next retirement is 2 cycles after the branch.
- Reset mid-store: mem_req drops asynchronously and the store is lost. Upstream reset also clears the ROB.

## Configuration
- `RETIRE_PERF_CNT_EN` defined:
  - Adds output `perf_retired` (32-bit) counting every retire_en cycle. It wraps at 2^32 and is reset to 0.
  - Adds `perf_flushes` (16-bit), counting flush pulses and saturating at 0xFFFF.
- Undefined: the ports and counters are absent. The remaining behaviour is identical.

## Structure
- `dispatch_type` and a new enum `retire_state_e` {RUN, ST_WAIT, FLUSH} go in the shared utils package. XLEN/TAG_W/REG_W defaults go there too.
- The retire-bus inputs bind through the `retire_bus` interface, using a new `retire` modport with the same signal set.
- One sub-module: `retire_store_if`, the store request/ack holding register plus its handshake.

## Test plan
- INT head, rd=5, tag=12, data=0xDEADBEEF, ready → same cycle: retire_en=1, arf write x5=0xDEADBEEF, RST clear (5,12).
- INT head with rd=0 → retire_en=1, arf_wen=0, rst_clr_en=1.
- STORE, addr=0x100, data=0x55, mem_ack delayed 3 cycles → mem_req is held 3 cycles with stable addr/data, and retire_en pulses exactly once, in the ack cycle.
- BRANCH taken, target 0x2000 → flush=1 and redirect_pc=0x2000 for 1 cycle. A ready INT head in the next cycle is not retired; it is retired the cycle after.
- Not-taken branch followed by an INT → both retire back-to-back, with no flush.
- Assert i_rst_n low in ST_WAIT → mem_req drops immediately. After release: RUN, all outputs 0, and with `RETIRE_PERF_CNT_EN` the counters read 0.

Source files
------------

// File: rtl/retire_unit_pkg.sv
// Shared types and default widths for the retire stage: instruction classes,
// retire FSM states and the XLEN/TAG_W/REG_W defaults.
package retire_unit_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_TAG_W = 6;
   localparam int DEF_REG_W = 5;

   typedef enum logic [2:0] {
      INT    = 3'd0,
      MULT   = 3'd1,
      DIV    = 3'd2,
      LOAD   = 3'd3,
      STORE  = 3'd4,
      BRANCH = 3'd5
   } dispatch_type;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      ST_WAIT = 2'd1,
      FLUSH   = 2'd2
   } retire_state_e;

endpackage

// File: rtl/retire_unit_if.sv
// ROB-head retire bus. The ROB drives it through master; the commit stage
// reads it through retire (slave is the generic reader view).
interface retire_bus
   import retire_unit_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int TAG_W = DEF_TAG_W,
   parameter int REG_W = DEF_REG_W
) ();

   logic              valid;
   logic              spec_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [REG_W-1:0]  rd_reg;
   logic [XLEN-1:0]   data;
   logic [XLEN-1:0]   pc;
   dispatch_type      instr_type;
   logic              branch_taken;
   logic [XLEN-1:0]   store_data;

   modport master (
      output valid, spec_valid, rd_tag, rd_reg, data, pc,
             instr_type, branch_taken, store_data
   );

   modport slave (
      input  valid, spec_valid, rd_tag, rd_reg, data, pc,
             instr_type, branch_taken, store_data
   );

   modport retire (
      input  valid, spec_valid, rd_tag, rd_reg, data, pc,
             instr_type, branch_taken, store_data
   );

endinterface

// File: rtl/retire_unit_store.sv
// Store holding register: captures address/data when a store head is taken
// and keeps the request asserted, unchanged, until the commit FSM sees the ack.
module retire_store_if #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            done,
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (start) begin
         mem_req   <= 1'b1;
         mem_addr  <= st_addr;
         mem_wdata <= st_data;
      end else if (done) begin
         mem_req   <= 1'b0;
      end
   end

endmodule

// File: rtl/retire_unit.sv
// In-order commit stage at the ROB head: ARF write, tag release, blocking
// store handshake and taken-branch flush. Optional counters: RETIRE_PERF_CNT_EN.
module retire_unit
   import retire_unit_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int TAG_W = DEF_TAG_W,
   parameter int REG_W = DEF_REG_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   retire_bus.retire        rb,
   output logic             retire_en,
   output logic             arf_wen,
   output logic [REG_W-1:0] arf_waddr,
   output logic [XLEN-1:0]  arf_wdata,
   output logic             rst_clr_en,
   output logic [REG_W-1:0] rst_clr_reg,
   output logic [TAG_W-1:0] rst_clr_tag,
   output logic             mem_req,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_wdata,
   input  logic             mem_ack,
`ifdef RETIRE_PERF_CNT_EN
   output logic [31:0]      perf_retired,
   output logic [15:0]      perf_flushes,
`endif
   output logic             flush,
   output logic [XLEN-1:0]  redirect_pc
);

   retire_state_e state, state_next;
   logic          head_ready;
   logic          store_start;
   logic          store_done;

   assign head_ready = rb.valid & rb.spec_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= RUN;
      else          state <= state_next;
   end

   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_next  = state;
      retire_en   = 1'b0;
      arf_wen     = 1'b0;
      arf_waddr   = '0;
      arf_wdata   = '0;
      rst_clr_en  = 1'b0;
      rst_clr_reg = '0;
      rst_clr_tag = '0;
      flush       = 1'b0;
      redirect_pc = '0;
      store_start = 1'b0;
      store_done  = 1'b0;
      case (state)
         RUN: begin
            if (head_ready) begin
               case (rb.instr_type)
                  INT, MULT, DIV, LOAD: begin
                     retire_en   = 1'b1;
                     arf_wen     = (rb.rd_reg != '0);
                     arf_waddr   = rb.rd_reg;
                     arf_wdata   = rb.data;
                     rst_clr_en  = 1'b1;
                     rst_clr_reg = rb.rd_reg;
                     rst_clr_tag = rb.rd_tag;
                  end
                  STORE: begin
                     store_start = 1'b1;
                     state_next  = ST_WAIT;
                  end
                  BRANCH: begin
                     retire_en = 1'b1;
                     // Static not-taken prediction: any taken branch mispredicted.
                     if (rb.branch_taken) begin
                        flush       = 1'b1;
                        redirect_pc = rb.data;
                        state_next  = FLUSH;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               retire_en  = 1'b1;
               store_done = 1'b1;
               state_next = RUN;
            end
         end
         FLUSH:   state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   retire_store_if #(.XLEN(XLEN)) u_store (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .start     (store_start),
      .done      (store_done),
      .st_addr   (rb.data),
      .st_data   (rb.store_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

`ifdef RETIRE_PERF_CNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perf_retired <= '0;
         perf_flushes <= '0;
      end else begin
         if (retire_en)                     perf_retired <= perf_retired + 32'd1;
         if (flush && perf_flushes != '1)   perf_flushes <= perf_flushes + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: table of single-cycle RUN vectors plus
// hand-written store, flush and reset sequences.
module tb_retire_unit;
   import retire_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        retire_en, arf_wen, rst_clr_en, mem_req, mem_ack, flush;
   logic [4:0]  arf_waddr, rst_clr_reg;
   logic [5:0]  rst_clr_tag;
   logic [31:0] arf_wdata, mem_addr, mem_wdata, redirect_pc;
`ifdef RETIRE_PERF_CNT_EN
   logic [31:0] perf_retired;
   logic [15:0] perf_flushes;
`endif

   int n_vec = 0;
   int n_err = 0;
   int exp_retired = 0;
   int exp_flushes = 0;
   int pulses;

   retire_bus #(.XLEN(32), .TAG_W(6), .REG_W(5)) rb_if ();

   retire_unit dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .rb          (rb_if.retire),
      .retire_en   (retire_en),
      .arf_wen     (arf_wen),
      .arf_waddr   (arf_waddr),
      .arf_wdata   (arf_wdata),
      .rst_clr_en  (rst_clr_en),
      .rst_clr_reg (rst_clr_reg),
      .rst_clr_tag (rst_clr_tag),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
`ifdef RETIRE_PERF_CNT_EN
      .perf_retired(perf_retired),
      .perf_flushes(perf_flushes),
`endif
      .flush       (flush),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         valid;
      logic         spec_valid;
      logic [5:0]   tag;
      logic [4:0]   rd;
      logic [31:0]  data;
      dispatch_type typ;
      logic         taken;
      logic         exp_ret;
      logic         exp_wen;
      logic         exp_clr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic sv, input logic [5:0] tag,
                        input logic [4:0] rd, input logic [31:0] data,
                        input dispatch_type typ, input logic taken,
                        input logic [31:0] sdata);
      rb_if.valid        = v;
      rb_if.spec_valid   = sv;
      rb_if.rd_tag       = tag;
      rb_if.rd_reg       = rd;
      rb_if.data         = data;
      rb_if.pc           = 32'h0000_1000;
      rb_if.instr_type   = typ;
      rb_if.branch_taken = taken;
      rb_if.store_data   = sdata;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 6'd0, 5'd0, 32'd0, INT, 1'b0, 32'd0);
   endtask

   initial begin
      vecs[0] = '{"int_rd5",  1, 1, 6'd12, 5'd5,  32'hDEAD_BEEF, INT,    0, 1, 1, 1};
      vecs[1] = '{"int_rd0",  1, 1, 6'd7,  5'd0,  32'h0000_1234, INT,    0, 1, 0, 1};
      vecs[2] = '{"mult",     1, 1, 6'd3,  5'd9,  32'h0000_00AA, MULT,   0, 1, 1, 1};
      vecs[3] = '{"div",      1, 1, 6'd63, 5'd31, 32'hFFFF_FFFF, DIV,    0, 1, 1, 1};
      vecs[4] = '{"load",     1, 1, 6'd0,  5'd1,  32'h8000_0000, LOAD,   0, 1, 1, 1};
      vecs[5] = '{"br_nt",    1, 1, 6'd2,  5'd4,  32'h0000_4000, BRANCH, 0, 1, 0, 0};
      vecs[6] = '{"no_valid", 0, 1, 6'd8,  5'd6,  32'h0000_0001, INT,    0, 0, 0, 0};
      vecs[7] = '{"no_wb",    1, 0, 6'd9,  5'd7,  32'h0000_0002, STORE,  0, 0, 0, 0};

      rst_n   = 1'b0;
      mem_ack = 1'b0;
      idle();

      // Reset state
      #12;
      check("rst_retire_en", retire_en, 0);
      check("rst_mem_req",   mem_req,   0);
      check("rst_mem_addr",  mem_addr,  0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_flush",     flush,     0);
      check("rst_arf_wen",   arf_wen,   0);
      check("rst_clr_en",    rst_clr_en,0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Single-cycle vectors in RUN
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].valid, vecs[i].spec_valid, vecs[i].tag, vecs[i].rd,
               vecs[i].data, vecs[i].typ, vecs[i].taken, 32'h0);
         @(negedge clk);
         check({vecs[i].name, "_retire_en"},  retire_en,  vecs[i].exp_ret);
         check({vecs[i].name, "_arf_wen"},    arf_wen,    vecs[i].exp_wen);
         check({vecs[i].name, "_rst_clr_en"}, rst_clr_en, vecs[i].exp_clr);
         check({vecs[i].name, "_flush"},      flush,      0);
         if (vecs[i].exp_wen) begin
            check({vecs[i].name, "_arf_waddr"}, arf_waddr, vecs[i].rd);
            check({vecs[i].name, "_arf_wdata"}, arf_wdata, vecs[i].data);
         end
         if (vecs[i].exp_clr) begin
            check({vecs[i].name, "_clr_reg"}, rst_clr_reg, vecs[i].rd);
            check({vecs[i].name, "_clr_tag"}, rst_clr_tag, vecs[i].tag);
         end
         if (vecs[i].exp_ret) exp_retired++;
      end

      // The not-ready STORE must not have launched a request
      @(posedge clk); #1 idle(); mem_ack = 1'b1;
      @(negedge clk);
      check("no_wb_store_req", mem_req,   0);
      check("ack_in_run",      retire_en, 0);
      @(posedge clk); #1 mem_ack = 1'b0;

      // Store with ack delayed 3 cycles
      drive(1'b1, 1'b1, 6'd20, 5'd0, 32'h0000_0100, STORE, 1'b0, 32'h0000_0055);
      @(negedge clk);
      check("st_issue_retire", retire_en, 0);
      check("st_issue_req",    mem_req,   0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         mem_ack = (i == 2);
         if (i == 1) rb_if.store_data = 32'hBAD0_BAD0;
         @(negedge clk);
         check("st_wait_req",   mem_req,   1);
         check("st_wait_addr",  mem_addr,  32'h100);
         check("st_wait_wdata", mem_wdata, 32'h55);
         check("st_wait_retire", retire_en, (i == 2));
         if (retire_en) pulses++;
      end
      exp_retired++;
      @(posedge clk); #1 idle(); mem_ack = 1'b0;
      @(negedge clk);
      check("st_done_req",    mem_req,   0);
      check("st_done_retire", retire_en, 0);
      check("st_pulses",      pulses,    1);

      // Taken branch: flush pulse, one drain cycle, then retire
      @(posedge clk); #1 drive(1'b1, 1'b1, 6'd4, 5'd3, 32'h0000_2000, BRANCH, 1'b1, 32'h0);
      @(negedge clk);
      check("br_t_retire",   retire_en,   1);
      check("br_t_flush",    flush,       1);
      check("br_t_redirect", redirect_pc, 32'h2000);
      check("br_t_arf_wen",  arf_wen,     0);
      check("br_t_clr_en",   rst_clr_en,  0);
      exp_retired++;
      exp_flushes++;
      @(posedge clk); #1 drive(1'b1, 1'b1, 6'd1, 5'd6, 32'h0000_0077, INT, 1'b0, 32'h0);
      @(negedge clk);
      check("drain_retire", retire_en, 0);
      check("drain_flush",  flush,     0);
      check("drain_wen",    arf_wen,   0);
      @(posedge clk);
      @(negedge clk);
      check("post_drain_retire", retire_en, 1);
      check("post_drain_wdata",  arf_wdata, 32'h77);
      check("post_drain_flush",  flush,     0);
      exp_retired++;

      // Not-taken branch then INT, back to back
      @(posedge clk); #1 drive(1'b1, 1'b1, 6'd5, 5'd2, 32'h0000_3000, BRANCH, 1'b0, 32'h0);
      @(negedge clk);
      check("nt_retire", retire_en, 1);
      check("nt_flush",  flush,     0);
      @(posedge clk); #1 drive(1'b1, 1'b1, 6'd6, 5'd8, 32'h0000_0123, INT, 1'b0, 32'h0);
      @(negedge clk);
      check("nt_int_retire", retire_en, 1);
      check("nt_int_wen",    arf_wen,   1);
      check("nt_int_flush",  flush,     0);
      exp_retired += 2;
      @(posedge clk); #1 idle();
      @(negedge clk);
`ifdef RETIRE_PERF_CNT_EN
      check("perf_retired", perf_retired, exp_retired);
      check("perf_flushes", perf_flushes, exp_flushes);
`endif

      // Reset in the middle of a store
      @(posedge clk); #1 drive(1'b1, 1'b1, 6'd9, 5'd0, 32'h0000_0300, STORE, 1'b0, 32'h0000_0099);
      @(posedge clk); #1;
      check("mid_st_req", mem_req, 1);
      #2 rst_n = 1'b0; idle();
      #1;
      check("mid_rst_req",  mem_req,  0);
      check("mid_rst_addr", mem_addr, 0);
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_req",    mem_req,   0);
      check("post_rst_wdata",  mem_wdata, 0);
      check("post_rst_retire", retire_en, 0);
      check("post_rst_flush",  flush,     0);
`ifdef RETIRE_PERF_CNT_EN
      check("post_rst_perf_retired", perf_retired, 0);
      check("post_rst_perf_flushes", perf_flushes, 0);
`endif
      drive(1'b1, 1'b1, 6'd10, 5'd11, 32'h0000_0456, INT, 1'b0, 32'h0);
      @(negedge clk);
      check("post_rst_run_retire", retire_en, 1);
      check("post_rst_run_wen",    arf_wen,   1);
      @(posedge clk); #1 idle();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
